// File: rtl/fetch_pkg.sv
// Shared constants for the RV32I instruction fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int PC_INC = 4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // ADDI x0,x0,0
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of packed {insn, pc} entries; head is straight from
// the entry registers.
module fetch_fifo import fetch_pkg::*; #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [DEPTH-1:0][W-1:0]   ents;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [W-1:0] ent_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                           ent_q <= '0;
      else if (push && !flush && wr_ptr == PTR_W'(i))       ent_q <= push_data;
    end
    assign ents[i] = ent_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = ents[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited word requests, in-order response buffering,
// redirect flush with drop accounting for stale in-flight responses.
module fetch_unit import fetch_pkg::*; #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_insn,
  output logic [XLEN-1:0] out_pc
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]   fetch_pc, rsp_pc, redir_pc;
  logic [CNT_W-1:0]  inflight, drop_cnt, count;
  logic              credit_ok, req_acc, push, pop;
  logic [2*XLEN-1:0] head;

  // Credits cover both in-flight requests and occupied entries, so a push
  // always finds room.
  assign credit_ok      = ({1'b0, inflight} + {1'b0, count}) < (CNT_W+1)'(DEPTH);
  assign imem_req_valid = reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_acc        = imem_req_valid && imem_req_ready;

  assign push      = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign redir_pc  = redirect_pc & ~XLEN'(3);

  fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign {out_insn, out_pc} = head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CNT_W'(req_acc) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
        // Every request still outstanding after this edge is stale, whether
        // or not an earlier redirect had already marked it.
        drop_cnt <= inflight - CNT_W'(imem_rsp_valid);
      end else begin
        if (req_acc) fetch_pc <= fetch_pc + XLEN'(PC_INC);
        if (imem_rsp_valid) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
          else                rsp_pc   <= rsp_pc + XLEN'(PC_INC);
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model and
// an in-order instruction memory model.
module tb_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, out_valid, out_ready;
  logic [31:0] redirect_pc, out_insn, out_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state
  logic [31:0] m_fetch, m_rsp, stream_pc;
  int          m_inflight, m_drop;
  logic [63:0] m_q[$];
  // memory model
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  // stimulus knobs
  int k_ready = 100, k_oready = 100, k_redir = 0, k_lat_min = 1, k_lat_max = 1;
  bit force_redir = 0;
  logic [31:0] force_pc;
  // observations
  int          accepts;
  logic [31:0] last_acc_addr;
  logic [31:0] pop_pc[$], pop_insn[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0160_8093;
    if (a == 32'h4) return 32'h0120_F113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fetch = RESET_PC; m_rsp = RESET_PC; stream_pc = RESET_PC;
    m_inflight = 0; m_drop = 0;
    m_q.delete(); mq_addr.delete(); mq_due.delete();
  endtask

  // One clock cycle: entered and left just after a negedge.
  task automatic step();
    bit          m_rv, dut_acc, rsp, acc, pop;
    logic [31:0] acc_addr, rsp_data, s_pc, s_insn;
    out_ready      = ($urandom_range(99) < k_oready);
    imem_req_ready = ($urandom_range(99) < k_ready);
    if (force_redir) begin
      redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 0;
    end else begin
      redirect_valid = ($urandom_range(99) < k_redir);
      redirect_pc    = $urandom;
    end
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
    #1;
    m_rv = !redirect_valid && (m_inflight + m_q.size()) < DEPTH;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_rv});
    chk("req_addr", imem_req_addr, m_fetch);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0][31:0]);
      chk("out_insn", out_insn, m_q[0][63:32]);
    end
    dut_acc = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    rsp = imem_rsp_valid; rsp_data = imem_rsp_data;
    acc = m_rv && imem_req_ready;
    pop = (m_q.size() != 0) && out_ready && !redirect_valid;
    s_pc = out_pc; s_insn = out_insn;
    @(posedge clk);
    cyc++;
    if (rsp) begin void'(mq_addr.pop_front()); void'(mq_due.pop_front()); end
    if (dut_acc) begin
      mq_addr.push_back(acc_addr);
      mq_due.push_back(cyc + $urandom_range(k_lat_max, k_lat_min) - 1);
      accepts++; last_acc_addr = acc_addr;
    end
    if (pop) begin
      // stream-level rule: consumed PCs are consecutive from the last target
      chk("stream_pc", s_pc, stream_pc);
      chk("stream_insn", s_insn, mem_word(s_pc));
      pop_pc.push_back(s_pc); pop_insn.push_back(s_insn);
      stream_pc += 32'd4;
      void'(m_q.pop_front());
    end
    if (redirect_valid) begin
      m_q.delete();
      m_inflight = m_inflight - int'(rsp);
      m_drop     = m_inflight;
      m_fetch    = redirect_pc & ~32'd3;
      m_rsp      = m_fetch;
      stream_pc  = m_fetch;
    end else begin
      m_inflight = m_inflight + int'(acc) - int'(rsp);
      if (acc) m_fetch += 32'd4;
      if (rsp) begin
        if (m_drop > 0) m_drop--;
        else begin m_q.push_back({rsp_data, m_rsp}); m_rsp += 32'd4; end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] a0;
    reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    #25;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_insn", out_insn, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1; model_reset();

    // basic stream, latency 1
    step(); chk("lat_c1_valid", {31'b0, out_valid}, 32'd0);
    step(); chk("lat_c2_valid", {31'b0, out_valid}, 32'd1);
    chk("basic_pc0", out_pc, 32'h0); chk("basic_insn0", out_insn, 32'h0160_8093);
    step(); chk("basic_pc1", out_pc, 32'h4); chk("basic_insn1", out_insn, 32'h0120_F113);

    // backpressure
    do_reset(); k_oready = 0; accepts = 0;
    repeat (10) step();
    chk("bp_accepts", accepts, DEPTH);
    chk("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("bp_out_pc", out_pc, 32'h0);
    k_oready = 100; pop_pc.delete(); pop_insn.delete();
    repeat (10) step();
    for (int i = 0; i < 4; i++) chk("bp_seq", pop_pc[i], 32'(i * 4));

    // redirect with two requests in flight
    do_reset(); k_lat_min = 6; k_lat_max = 6;
    step(); step();
    pop_pc.delete(); pop_insn.delete();
    force_redir = 1; force_pc = 32'h43; k_lat_min = 1; k_lat_max = 1;
    repeat (15) step();
    chk("redir_pc", pop_pc[0], 32'h40);
    chk("redir_insn", pop_insn[0], mem_word(32'h40));

    // memory stall
    k_ready = 0; step(); a0 = imem_req_addr;
    repeat (5) begin step(); chk("stall_addr", imem_req_addr, a0); end
    k_ready = 100; step();
    chk("stall_acc_addr", last_acc_addr, a0);

    // wrap-around
    pop_pc.delete(); pop_insn.delete();
    force_redir = 1; force_pc = 32'hFFFF_FFFC;
    repeat (8) step();
    chk("wrap_pc0", pop_pc[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", pop_pc[1], 32'h0);
    chk("wrap_insn1", pop_insn[1], 32'h0160_8093);

    // asynchronous reset pulse while out_valid is high
    k_oready = 0; repeat (4) step();
    chk("arst_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    #4 reset = 1'b1;
    model_reset(); k_oready = 100;
    chk("arst_restart_addr", imem_req_addr, RESET_PC);
    step();
    chk("arst_first_acc", last_acc_addr, RESET_PC);

    // randomized traffic
    k_ready = 70; k_oready = 70; k_redir = 5; k_lat_min = 1; k_lat_max = 4;
    repeat (3000) step();
    k_redir = 0;
    repeat (50) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
